// File: rtl/tmcu_uart_pkg.sv
// Shared types for the UART transmit queue: the drain FSM state and the default depth.
package tmcu_uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT_LO,
    WAIT_HI
  } txq_state_t;

  localparam int TXQ_DEFAULT_DEPTH = 16;

endpackage

// File: rtl/tmcu_sync_fifo.sv
// Single-clock FIFO with an explicit occupancy counter and a synchronous flush.
// Rejects pushes while full and pops while empty; flush overrides both.
module tmcu_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  // full/empty are taken from the pre-edge count, so a push into a full queue
  // is rejected even when a pop happens on the same edge.
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign push_ok = push_i && !full_o && !flush_i;
  assign pop_ok  = pop_i && !empty_o && !flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push_ok && !pop_ok)      count_d = count_q + (AW+1)'(1);
      else if (pop_ok && !push_ok) count_d = count_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/tmcu_uart_txq.sv
// Transmit byte queue feeding the UART: buffers bus writes, hands one byte at a time to the UART.
// Optional low-water interrupt is built when TMCU_UART_TXQ_IRQ_EN is defined; otherwise irq is 0.
module tmcu_uart_txq
  import tmcu_uart_pkg::*;
#(
  parameter int DEPTH     = TXQ_DEFAULT_DEPTH,
  parameter int LOW_WATER = 2,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic [7:0]  wr_data,
  input  logic        flush,
  output logic        full,
  output logic        empty,
  output logic [AW:0] count,
  output logic        overflow,
  output logic        busy,
  output logic        irq,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  input  logic        tx_ready
);

  txq_state_t  state_q;
  logic        tx_start_q;
  logic [7:0]  tx_data_q;
  logic        overflow_q;
  logic [7:0]  fifo_head;
  logic [AW:0] fifo_count;
  logic        pop;

  tmcu_sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (wr_en),
    .push_data_i (wr_data),
    .pop_i       (pop),
    .flush_i     (flush),
    .head_o      (fifo_head),
    .full_o      (full),
    .empty_o     (empty),
    .count_o     (fifo_count)
  );

  assign pop      = (state_q == IDLE) && !empty && tx_ready && !flush;
  assign count    = fifo_count;
  assign busy     = (state_q != IDLE) || !empty;
  assign overflow = overflow_q;
  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;

  // Flush only touches the queue; a byte already handed to the UART runs to completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
    end else begin
      tx_start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pop) begin
            tx_data_q  <= fifo_head;
            tx_start_q <= 1'b1;
            state_q    <= START;
          end
        end
        START:   state_q <= WAIT_LO;
        WAIT_LO: if (!tx_ready) state_q <= WAIT_HI;
        WAIT_HI: if (tx_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              overflow_q <= 1'b0;
    else if (flush)          overflow_q <= 1'b0;
    else if (wr_en && full)  overflow_q <= 1'b1;
  end

`ifdef TMCU_UART_TXQ_IRQ_EN
  logic irq_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) irq_q <= 1'b0;
    else        irq_q <= (int'(fifo_count) <= LOW_WATER);
  end

  assign irq = irq_q;
`else
  // LOW_WATER only matters with the interrupt built in.
  logic low_water_unused;
  assign low_water_unused = (LOW_WATER < 0);
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_tmcu_uart_txq.sv
// Randomised bench for tmcu_uart_txq against a queue-level reference model and a simple UART responder.
module tb_tmcu_uart_txq;

  localparam int DEPTH = 16;
  localparam int LW    = 2;
  localparam int AW    = $clog2(DEPTH);

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [7:0]  wr_data = 8'h00;
  logic        flush = 1'b0;
  logic        tx_ready = 1'b1;
  logic        full, empty, overflow, busy, irq, tx_start;
  logic [AW:0] count;
  logic [7:0]  tx_data;

  always #5 clk = ~clk;

  tmcu_uart_txq #(
    .DEPTH     (DEPTH),
    .LOW_WATER (LW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .flush    (flush),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow),
    .busy     (busy),
    .irq      (irq),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx_ready (tx_ready)
  );

  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: queue contents, sticky overflow, byte-in-flight tracking.
  logic [7:0] mq[$];
  logic [7:0] sent_q[$];
  bit         m_ovf, m_inflight, m_started, m_seen_low, m_txstart, m_irq;
  logic [7:0] m_txdata;

  // UART responder
  bit hold;
  bit u_busy;
  int u_frame;
  int max_frame = 4;

  task automatic check_outputs();
    chk_eq("count", 32'(count), 32'(mq.size()));
    chk_eq("full", 32'(full), 32'(mq.size() == DEPTH));
    chk_eq("empty", 32'(empty), 32'(mq.size() == 0));
    chk_eq("overflow", 32'(overflow), 32'(m_ovf));
    chk_eq("busy", 32'(busy), 32'(m_inflight || mq.size() > 0));
    chk_eq("tx_start", 32'(tx_start), 32'(m_txstart));
    chk_eq("tx_data", 32'(tx_data), 32'(m_txdata));
`ifdef TMCU_UART_TXQ_IRQ_EN
    chk_eq("irq", 32'(irq), 32'(m_irq));
`else
    chk_eq("irq", 32'(irq), 32'(0));
`endif
  endtask

  task automatic set_hold(input bit b);
    hold = b;
    tx_ready = !hold && !u_busy;
  endtask

  task automatic reset_model();
    mq.delete();
    sent_q.delete();
    m_ovf = 0; m_inflight = 0; m_started = 0; m_seen_low = 0;
    m_txstart = 0; m_irq = 0; m_txdata = 8'h00;
    u_busy = 0; u_frame = 0;
    tx_ready = !hold;
  endtask

  task automatic do_reset();
    wr_en = 1'b0; flush = 1'b0;
    rst_n = 1'b0;
    #1;
    reset_model();
    check_outputs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // One clock: drive inputs, advance model on pre-edge values, then compare after the edge.
  task automatic step(input bit w, input logic [7:0] d, input bit f);
    int cnt;
    bit full_pre, pop;
    wr_en = w; wr_data = d; flush = f;
    cnt = mq.size();
    full_pre = (cnt == DEPTH);
    pop = !m_inflight && cnt > 0 && tx_ready && !f;

    // In flight: one start slot, then wait for the UART to go busy, then idle again.
    if (pop) begin
      m_inflight = 1; m_started = 0; m_seen_low = 0;
    end else if (m_inflight) begin
      if (!m_started) m_started = 1;
      else if (!m_seen_low) begin
        if (!tx_ready) m_seen_low = 1;
      end else if (tx_ready) m_inflight = 0;
    end
    m_txstart = pop;
    m_irq = (cnt <= LW);

    if (f) begin
      mq.delete();
      m_ovf = 0;
    end else begin
      if (w && full_pre) m_ovf = 1;
      if (pop) begin
        m_txdata = mq.pop_front();
        sent_q.push_back(m_txdata);
      end
      if (w && !full_pre) mq.push_back(d);
    end

    if (tx_start === 1'b1) begin
      chk_eq("rx_expected", 32'(sent_q.size() > 0), 32'(1));
      if (sent_q.size() > 0) chk_eq("rx_byte", 32'(tx_data), 32'(sent_q.pop_front()));
      u_busy = 1;
      u_frame = $urandom_range(max_frame, 0);
    end else if (u_busy) begin
      if (u_frame > 0) u_frame--;
      else u_busy = 0;
    end

    @(posedge clk);
    #1;
    tx_ready = !hold && !u_busy;
    check_outputs();
  endtask

  task automatic run_idle(input int n);
    for (int i = 0; i < n; i++) step(0, 8'h00, 0);
  endtask

  task automatic drain(input string tag, input int bound);
    int i;
    i = 0;
    while ((mq.size() > 0 || m_inflight) && i < bound) begin
      step(0, 8'h00, 0);
      i++;
    end
    chk_eq({tag, "_drained"}, 32'(mq.size() == 0 && !m_inflight), 32'(1));
    run_idle(max_frame + 4);
    chk_eq({tag, "_rx_all"}, 32'(sent_q.size()), 32'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int i;
    bit w, f;
    hold = 0;
    do_reset();

    // Single byte with idle UART
    step(1, 8'hA5, 0);
    chk_eq("lat_count1", 32'(count), 32'(1));
    step(0, 8'h00, 0);
    chk_eq("lat_start", 32'(tx_start), 32'(1));
    chk_eq("lat_data", 32'(tx_data), 32'(8'hA5));
    chk_eq("lat_count0", 32'(count), 32'(0));
    step(0, 8'h00, 0);
    chk_eq("lat_pulse_end", 32'(tx_start), 32'(0));
    drain("t1", 50);

    // Fill to full while UART busy, then overflow
    set_hold(1);
    for (int k = 0; k < DEPTH; k++) step(1, 8'(k), 0);
    chk_eq("fill_full", 32'(full), 32'(1));
    chk_eq("fill_count", 32'(count), 32'(16));
    step(1, 8'hEE, 0);
    chk_eq("ovf_set", 32'(overflow), 32'(1));
    chk_eq("ovf_count", 32'(count), 32'(16));
    set_hold(0);
    drain("t2", 400);
    step(0, 8'h00, 1);
    chk_eq("flush_ovf_clr", 32'(overflow), 32'(0));

    // tx_ready held low for 20 cycles with 3 queued
    set_hold(1);
    for (int k = 0; k < 3; k++) step(1, 8'h30 + 8'(k), 0);
    run_idle(20);
    set_hold(0);
    drain("t3", 100);

    // Flush while a byte is in flight
    max_frame = 6;
    for (int k = 0; k < 5; k++) step(1, 8'h50 + 8'(k), 0);
    i = 0;
    while (!(m_inflight && !tx_ready) && i < 20) begin
      step(0, 8'h00, 0);
      i++;
    end
    chk_eq("t4_in_wait", 32'(m_inflight && !tx_ready), 32'(1));
    step(1, 8'h99, 1);
    chk_eq("t4_count", 32'(count), 32'(0));
    chk_eq("t4_ovf", 32'(overflow), 32'(0));
    run_idle(30);
    chk_eq("t4_rx_all", 32'(sent_q.size()), 32'(0));

    // Full queue, write coinciding with a pop
    set_hold(1);
    for (int k = 0; k < DEPTH; k++) step(1, 8'hC0 + 8'(k), 0);
    set_hold(0);
    step(1, 8'h77, 0);
    chk_eq("t5_count", 32'(count), 32'(15));
    chk_eq("t5_ovf", 32'(overflow), 32'(1));
    drain("t5", 400);
    step(0, 8'h00, 1);

    // Randomised traffic with a reset in the middle
    for (int k = 0; k < 700; k++) begin
      if (k == 350) do_reset();
      if ($urandom_range(99) < 2) set_hold(!hold);
      if ($urandom_range(99) < 5) max_frame = $urandom_range(6, 0);
      w = ($urandom_range(99) < 45);
      f = ($urandom_range(99) < 3);
      step(w, 8'($urandom), f);
    end
    set_hold(0);
    max_frame = 4;
    drain("rnd", 400);

    // Reset while a byte is in flight
    for (int k = 0; k < 3; k++) step(1, 8'hE0 + 8'(k), 0);
    step(0, 8'h00, 0);
    do_reset();
    run_idle(10);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
